// File: rtl/nn_pkg.sv
// Shared types and width helpers for the dense-layer sequencer.
package nn_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BIAS,
        S_MAC,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_e;

    // Wide enough for a full N-term dot product of WIDTH x WIDTH products plus a shifted bias.
    function automatic int acc_width(input int width, input int n);
        return 2 * width + $clog2(n) + 1;
    endfunction

    // Keeps single-entry memories at a 1-bit address rather than zero width.
    function automatic int addr_width(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/dense_seq_ctrl_if.sv
// Control handshake plus x/w/b read ports and y write port of the dense-layer sequencer.
interface dense_seq_ctrl_if #(
    parameter int B     = 15,
    parameter int M     = 64,
    parameter int N     = 2,
    parameter int WIDTH = 16
);
    import nn_pkg::*;

    localparam int XAW = addr_width(B * N);
    localparam int WAW = addr_width(M * N);
    localparam int BAW = addr_width(M);
    localparam int YAW = addr_width(B * M);

    logic                    start;
    logic                    busy;
    logic                    done;
    logic [XAW-1:0]          x_addr;
    logic signed [WIDTH-1:0] x_data;
    logic [WAW-1:0]          w_addr;
    logic signed [WIDTH-1:0] w_data;
    logic [BAW-1:0]          b_addr;
    logic signed [WIDTH-1:0] b_data;
    logic [YAW-1:0]          y_addr;
    logic signed [WIDTH-1:0] y_data;
    logic                    y_we;

    modport master (
        input  start, x_data, w_data, b_data,
        output busy, done, x_addr, w_addr, b_addr, y_addr, y_data, y_we
    );

    modport slave (
        output start, x_data, w_data, b_data,
        input  busy, done, x_addr, w_addr, b_addr, y_addr, y_data, y_we
    );

endinterface

// File: rtl/fxp_requant.sv
// Fixed-point requantisation: floor shift by FRAC, saturate to WIDTH, optional ReLU.
module fxp_requant #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int ACC_W = 34,
    parameter int RELU  = 1
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [WIDTH-1:0] y
);

    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic signed [ACC_W-1:0] shifted;
    logic signed [WIDTH-1:0] sat;

    always_comb begin
        shifted = acc >>> FRAC;
        if (shifted > MAX_V) begin
            sat = {1'b0, {(WIDTH-1){1'b1}}};
        end else if (shifted < MIN_V) begin
            sat = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            sat = shifted[WIDTH-1:0];
        end
        y = sat;
        if (RELU != 0 && sat[WIDTH-1]) begin
            y = '0;
        end
    end

endmodule

// File: rtl/dense_seq_ctrl.sv
// Sequencer for one dense layer: y[b][m] = requant(bias[m] + sum_k x[b][k]*w[m][k]).
//
// state   | meaning
// IDLE    | waiting for start; all outputs 0
// BIAS    | b_addr=m issued, bias word arrives next cycle
// MAC     | N cycles issuing x/w addresses; first cycle loads bias, rest accumulate
// DRAIN   | accumulate product of the last MAC address pair
// WRITE   | y_we=1 with requantised acc at b*M+m
// DONE    | one-cycle done pulse, back to IDLE
module dense_seq_ctrl
    import nn_pkg::*;
#(
    parameter int B     = 15,
    parameter int M     = 64,
    parameter int N     = 2,
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int RELU  = 1
) (
    input  logic             clk,
    input  logic             rst,
    dense_seq_ctrl_if.master bus
);

    localparam int ACC_W = acc_width(WIDTH, N);
    localparam int BW    = addr_width(B);
    localparam int MW    = addr_width(M);
    localparam int KW    = addr_width(N);
    localparam int XAW   = addr_width(B * N);
    localparam int WAW   = addr_width(M * N);
    localparam int YAW   = addr_width(B * M);

    state_e                  state_q, state_d;
    logic [BW-1:0]           b_q, b_d;
    logic [MW-1:0]           m_q, m_d;
    logic [KW-1:0]           k_q, k_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;

    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   bias_ext;
    logic signed [WIDTH-1:0]   y_req;

    assign prod     = bus.x_data * bus.w_data;
    assign prod_ext = {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
    assign bias_ext = {{(ACC_W-WIDTH){bus.b_data[WIDTH-1]}}, bus.b_data} <<< FRAC;

    fxp_requant #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC),
        .ACC_W (ACC_W),
        .RELU  (RELU)
    ) u_requant (
        .acc (acc_q),
        .y   (y_req)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            b_q     <= '0;
            m_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            m_q     <= m_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        b_d        = b_q;
        m_d        = m_q;
        k_d        = k_q;
        acc_d      = acc_q;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        bus.x_addr = '0;
        bus.w_addr = '0;
        bus.b_addr = '0;
        bus.y_addr = '0;
        bus.y_data = '0;
        bus.y_we   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_BIAS;
                    b_d     = '0;
                    m_d     = '0;
                    k_d     = '0;
                end
            end

            S_BIAS: begin
                bus.busy   = 1'b1;
                bus.b_addr = m_q;
                k_d        = '0;
                state_d    = S_MAC;
            end

            S_MAC: begin
                bus.busy   = 1'b1;
                bus.x_addr = XAW'(int'(b_q) * N + int'(k_q));
                bus.w_addr = WAW'(int'(m_q) * N + int'(k_q));
                // Data on the ports belongs to the previous cycle's address: bias first, then products.
                if (k_q == '0) begin
                    acc_d = bias_ext;
                end else begin
                    acc_d = acc_q + prod_ext;
                end
                if (k_q == KW'(N - 1)) begin
                    state_d = S_DRAIN;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end

            S_DRAIN: begin
                bus.busy = 1'b1;
                acc_d    = acc_q + prod_ext;
                state_d  = S_WRITE;
            end

            S_WRITE: begin
                bus.busy   = 1'b1;
                bus.y_we   = 1'b1;
                bus.y_addr = YAW'(int'(b_q) * M + int'(m_q));
                bus.y_data = y_req;
                if (m_q == MW'(M - 1)) begin
                    m_d = '0;
                    if (b_q == BW'(B - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        b_d     = b_q + BW'(1);
                        state_d = S_BIAS;
                    end
                end else begin
                    m_d     = m_q + MW'(1);
                    state_d = S_BIAS;
                end
            end

            S_DONE: begin
                bus.done = 1'b1;
                state_d  = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dense_seq_ctrl.sv
// Directed and randomized bench for dense_seq_ctrl against an arithmetic reference model.
module tb_dense_seq_ctrl;

    localparam int W = 16;
    localparam int F = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Two single-result instances differing only in RELU, plus a 2x3 multi-result instance.
    dense_seq_ctrl_if #(.B(1), .M(1), .N(2), .WIDTH(W)) if1 ();
    dense_seq_ctrl_if #(.B(1), .M(1), .N(2), .WIDTH(W)) if0 ();
    dense_seq_ctrl_if #(.B(2), .M(3), .N(2), .WIDTH(W)) ifm ();

    dense_seq_ctrl #(.B(1), .M(1), .N(2), .WIDTH(W), .FRAC(F), .RELU(1)) u_s1 (
        .clk (clk), .rst (rst), .bus (if1.master));
    dense_seq_ctrl #(.B(1), .M(1), .N(2), .WIDTH(W), .FRAC(F), .RELU(0)) u_s0 (
        .clk (clk), .rst (rst), .bus (if0.master));
    dense_seq_ctrl #(.B(2), .M(3), .N(2), .WIDTH(W), .FRAC(F), .RELU(0)) u_m (
        .clk (clk), .rst (rst), .bus (ifm.master));

    logic signed [W-1:0] sx [0:1];
    logic signed [W-1:0] sw [0:1];
    logic signed [W-1:0] sb [0:0];
    logic signed [W-1:0] mx [0:3];
    logic signed [W-1:0] mw [0:5];
    logic signed [W-1:0] mb [0:2];

    // Synchronous-read memories: data follows the address by one cycle.
    always @(posedge clk) begin
        if1.x_data <= sx[if1.x_addr];
        if1.w_data <= sw[if1.w_addr];
        if1.b_data <= sb[if1.b_addr];
        if0.x_data <= sx[if0.x_addr];
        if0.w_data <= sw[if0.w_addr];
        if0.b_data <= sb[if0.b_addr];
        ifm.x_data <= mx[ifm.x_addr];
        ifm.w_data <= mw[ifm.w_addr];
        ifm.b_data <= mb[ifm.b_addr];
    end

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Floor division by 2^F, clamp to the signed W-bit range, optional ReLU.
    function automatic longint ref_y(input longint bias, input longint dot, input bit relu);
        longint acc, q, div;
        div = longint'(1) << F;
        acc = bias * div + dot;
        q   = (acc - (((acc % div) + div) % div)) / div;
        if (q > (longint'(1) << (W - 1)) - 1) q = (longint'(1) << (W - 1)) - 1;
        if (q < -(longint'(1) << (W - 1)))    q = -(longint'(1) << (W - 1));
        if (relu && q < 0) q = 0;
        return q;
    endfunction

    int                  s_we_n, s_we_c, s_done_c, s_ya;
    logic signed [W-1:0] s_y1, s_y0;
    logic                s_busy_dn;

    task automatic run_small();
        @(negedge clk);
        if1.start = 1'b1;
        if0.start = 1'b1;
        s_we_n = 0; s_we_c = -1; s_done_c = -1; s_ya = -1;
        s_y1 = 'x; s_y0 = 'x; s_busy_dn = 1'bx;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if1.start = 1'b0;
            if0.start = 1'b0;
            if (if1.y_we) begin
                s_we_n++;
                s_we_c = c;
                s_ya   = int'(if1.y_addr);
                s_y1   = if1.y_data;
            end
            if (if0.y_we) s_y0 = if0.y_data;
            if (if1.done && s_done_c < 0) begin
                s_done_c  = c;
                s_busy_dn = if1.busy;
            end
        end
    endtask

    int                  g_addr [$];
    int                  g_cyc  [$];
    logic signed [W-1:0] g_data [$];
    int                  m_done_c;
    logic                m_busy_dn;

    task automatic run_m(input bit poke);
        g_addr.delete(); g_cyc.delete(); g_data.delete();
        m_done_c  = -1;
        m_busy_dn = 1'bx;
        @(negedge clk);
        ifm.start = 1'b1;
        for (int c = 1; c <= 60 && m_done_c < 0; c++) begin
            @(negedge clk);
            ifm.start = poke && (c % 6 == 2) && (c < 25);
            if (ifm.y_we) begin
                g_addr.push_back(int'(ifm.y_addr));
                g_data.push_back(ifm.y_data);
                g_cyc.push_back(c);
            end
            if (ifm.done) begin
                m_done_c  = c;
                m_busy_dn = ifm.busy;
            end
        end
        ifm.start = 1'b0;
    endtask

    task automatic check_m();
        longint dot;
        int     b, m;
        check("m_write_count", g_addr.size(), 6);
        for (int i = 0; i < 6 && i < g_addr.size(); i++) begin
            b   = i / 3;
            m   = i % 3;
            dot = 0;
            for (int k = 0; k < 2; k++) dot += longint'(mx[b*2+k]) * longint'(mw[m*2+k]);
            check("m_y_addr", g_addr[i], i);
            check("m_y_data", g_data[i], ref_y(longint'(mb[m]), dot, 1'b0));
            check("m_y_cycle", g_cyc[i], 5 * (i + 1));
        end
        check("m_done_cycle", m_done_c, 31);
        check("m_busy_at_done", m_busy_dn, 0);
    endtask

    task automatic randomize_m();
        for (int i = 0; i < 4; i++) mx[i] = W'(int'($urandom_range(4095)) - 2048);
        for (int i = 0; i < 6; i++) mw[i] = W'(int'($urandom_range(4095)) - 2048);
        for (int i = 0; i < 3; i++) mb[i] = W'($urandom);
    endtask

    int quiet_we, quiet_busy;

    initial begin
        rst = 1'b1;
        if1.start = 1'b0; if0.start = 1'b0; ifm.start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",   ifm.busy, 0);
        check("rst_done",   ifm.done, 0);
        check("rst_y_we",   ifm.y_we, 0);
        check("rst_x_addr", ifm.x_addr, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", ifm.busy, 0);

        sx[0] = 16'sd256; sx[1] = 16'sd512;
        sw[0] = 16'sd256; sw[1] = 16'sd128;
        sb[0] = 16'sd64;
        run_small();
        check("s_we_count",   s_we_n, 1);
        check("s_we_cycle",   s_we_c, 5);
        check("s_y_addr",     s_ya, 0);
        check("s_y_relu1",    s_y1, 576);
        check("s_y_relu0",    s_y0, 576);
        check("s_done_cycle", s_done_c, 6);
        check("s_busy_done",  s_busy_dn, 0);

        sb[0] = -16'sd2048;
        run_small();
        check("neg_y_relu1", s_y1, 0);
        check("neg_y_relu0", s_y0, -1536);

        sx[0] = 16'sd32767; sx[1] = 16'sd32767;
        sw[0] = 16'sd32767; sw[1] = 16'sd32767;
        sb[0] = 16'sd32767;
        run_small();
        check("sat_pos_relu1", s_y1, 32767);
        check("sat_pos_relu0", s_y0, 32767);

        sx[0] = -16'sd32767; sx[1] = -16'sd32767;
        sb[0] = -16'sd32767;
        run_small();
        check("sat_neg_relu0", s_y0, -32768);
        check("sat_neg_relu1", s_y1, 0);

        randomize_m();
        run_m(1'b0);
        check_m();

        randomize_m();
        run_m(1'b1);
        check_m();

        randomize_m();
        @(negedge clk);
        ifm.start = 1'b1;
        @(negedge clk);
        ifm.start = 1'b0;
        @(negedge clk);
        check("mid_busy_before_rst", ifm.busy, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy",   ifm.busy, 0);
        check("mid_rst_x_addr", ifm.x_addr, 0);
        check("mid_rst_w_addr", ifm.w_addr, 0);
        check("mid_rst_y_we",   ifm.y_we, 0);
        check("mid_rst_y_data", ifm.y_data, 0);
        @(negedge clk);
        rst = 1'b0;
        quiet_we = 0; quiet_busy = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ifm.y_we) quiet_we++;
            if (ifm.busy) quiet_busy++;
        end
        check("post_rst_no_we",   quiet_we, 0);
        check("post_rst_no_busy", quiet_busy, 0);

        randomize_m();
        run_m(1'b0);
        check_m();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
